// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit game PRNG and its receive-side checker:
// reset seed, next-state function and checker state encoding.
package lfsr_pkg;

  localparam logic [15:0] LFSR16_RESET = 16'hABCD;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // One step of the PRNG. Zero maps to zero, so zero must never seed it.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
    logic [15:0] n;
    n        = '0;
    n[15]    = q[15] ^ q[14];
    n[14:3]  = q[13:2];
    n[2]     = q[1] ^ q[15];
    n[1]     = q[0];
    n[0]     = q[15];
    return n;
  endfunction

endpackage

// File: rtl/lfsr_16_checker.sv
// Receive-side LFSR sequence checker. Hunts for a non-zero seed word,
// verifies LOCK_COUNT consecutive predictions, then flywheels its own
// predictor and flags every received word that departs from it.
// Optional: define LFSR_CHK_ZERO_DET_EN to add stuck_zero_out, which reports
// a source that has collapsed into the all-zero fixed point.
module lfsr_16_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             data_valid_in,
  input  logic [15:0]      data_in,
  output logic             locked_out,
  output logic             err_pulse_out,
  output logic [CNT_W-1:0] err_count_out,
  output logic [15:0]      expected_out
`ifdef LFSR_CHK_ZERO_DET_EN
  ,
  output logic             stuck_zero_out
`endif
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_COUNT - 1);

  chk_state_t         state_reg;
  logic [15:0]        pred_reg;
  logic [MATCH_W-1:0] match_cnt_reg;
  logic [MISS_W-1:0]  miss_cnt_reg;
  logic [CNT_W-1:0]   err_count_reg;
  logic               err_pulse_reg;

  logic [15:0] seed_next;
  logic [15:0] fly_next;
  logic        data_is_zero;
  logic        data_matches;

  // Candidate predictor values: re-seed from the received word, or flywheel.
  assign seed_next    = lfsr16_next(data_in);
  assign fly_next     = lfsr16_next(pred_reg);
  assign data_is_zero = (data_in == 16'h0000);
  assign data_matches = (data_in == pred_reg);

  // Hunt / verify / locked FSM with predictor, match/miss and error counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg     <= HUNT;
      pred_reg      <= LFSR16_RESET;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      err_count_reg <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      err_pulse_reg <= 1'b0;
      if (data_valid_in) begin
        case (state_reg)
          HUNT: begin
            if (!data_is_zero) begin
              pred_reg      <= seed_next;
              match_cnt_reg <= '0;
              state_reg     <= VERIFY;
            end
          end
          VERIFY: begin
            if (data_matches) begin
              pred_reg      <= seed_next;
              match_cnt_reg <= match_cnt_reg + 1'b1;
              if (match_cnt_reg == MATCH_LAST) begin
                state_reg    <= LOCKED;
                miss_cnt_reg <= '0;
              end
            end else if (!data_is_zero) begin
              pred_reg      <= seed_next;
              match_cnt_reg <= '0;
            end else begin
              state_reg <= HUNT;
            end
          end
          LOCKED: begin
            // Received data never re-seeds here; a corrupted word must not
            // drag the predictor off the true sequence.
            pred_reg <= fly_next;
            if (!data_matches) begin
              err_pulse_reg <= 1'b1;
              if (err_count_reg != {CNT_W{1'b1}}) begin
                err_count_reg <= err_count_reg + 1'b1;
              end
              miss_cnt_reg <= miss_cnt_reg + 1'b1;
              if (miss_cnt_reg == MISS_LAST) begin
                state_reg     <= HUNT;
                match_cnt_reg <= '0;
              end
            end else begin
              miss_cnt_reg <= '0;
            end
          end
          default: begin
            state_reg <= HUNT;
          end
        endcase
      end
    end
  end

  assign locked_out    = (state_reg == LOCKED);
  assign err_pulse_out = err_pulse_reg;
  assign err_count_out = err_count_reg;
  assign expected_out  = pred_reg;

`ifdef LFSR_CHK_ZERO_DET_EN
  localparam int ZRUN_W = $clog2(UNLOCK_COUNT + 1);
  localparam logic [ZRUN_W-1:0] ZRUN_LAST = ZRUN_W'(UNLOCK_COUNT - 1);
  localparam logic [ZRUN_W-1:0] ZRUN_SAT  = ZRUN_W'(UNLOCK_COUNT);

  logic [ZRUN_W-1:0] zero_run_reg;
  logic              stuck_zero_reg;

  // Count consecutive valid zero words in any state; saturate once stuck.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      zero_run_reg   <= '0;
      stuck_zero_reg <= 1'b0;
    end else if (data_valid_in) begin
      if (data_is_zero) begin
        if (zero_run_reg == ZRUN_LAST) begin
          stuck_zero_reg <= 1'b1;
        end
        if (zero_run_reg != ZRUN_SAT) begin
          zero_run_reg <= zero_run_reg + 1'b1;
        end
      end else begin
        zero_run_reg   <= '0;
        stuck_zero_reg <= 1'b0;
      end
    end
  end

  assign stuck_zero_out = stuck_zero_reg;
`endif

endmodule

// File: tb/tb_lfsr_16_checker.sv
// Directed self-checking bench for lfsr_16_checker (4-bit error counter build
// so saturation is reachable quickly).
module tb_lfsr_16_checker;

  localparam int CNT_W = 4;

  logic             clk_in;
  logic             rst_in;
  logic             data_valid_in;
  logic [15:0]      data_in;
  logic             locked_out;
  logic             err_pulse_out;
  logic [CNT_W-1:0] err_count_out;
  logic [15:0]      expected_out;
`ifdef LFSR_CHK_ZERO_DET_EN
  logic             stuck_zero_out;
`endif

  int checks;
  int failures;
  int exp_err;
  logic [15:0] w;

  lfsr_16_checker #(
    .LOCK_COUNT  (4),
    .UNLOCK_COUNT(3),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .data_valid_in(data_valid_in),
    .data_in      (data_in),
    .locked_out   (locked_out),
    .err_pulse_out(err_pulse_out),
    .err_count_out(err_count_out),
    .expected_out (expected_out)
`ifdef LFSR_CHK_ZERO_DET_EN
    ,
    .stuck_zero_out(stuck_zero_out)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference successor, written as a concatenation of the tap equations.
  function automatic logic [15:0] nxt(input logic [15:0] q);
    return {q[15] ^ q[14], q[13:2], q[1] ^ q[15], q[0], q[15]};
  endfunction

  // Present one input cycle, then return 1 time unit after the sampling edge.
  task automatic beat(input logic v, input logic [15:0] d);
    @(negedge clk_in);
    data_valid_in = v;
    data_in       = d;
    @(posedge clk_in);
    #1;
    data_valid_in = 1'b0;
  endtask

  // Seed with w, then feed four correct successors; leaves w = next prediction.
  task automatic relock();
    beat(1'b1, w);
    w = nxt(w);
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, w);
      w = nxt(w);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    data_valid_in = 1'b0;
    data_in = 16'h0000;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    checks++;
    if (locked_out !== 1'b0 || err_pulse_out !== 1'b0 || err_count_out !== 4'd0 ||
        expected_out !== 16'hABCD) begin
      failures++;
      $display("FAIL reset_values: locked=%b pulse=%b err=%0d exp=%h, required 0 0 0 abcd",
               locked_out, err_pulse_out, err_count_out, expected_out);
    end
    exp_err = 0;
    $display("test_reset: locked=%b err=%0d expected=%h", locked_out, err_count_out, expected_out);
  endtask

  task automatic test_lock();
    beat(1'b1, 16'hABCD);
    checks++;
    if (expected_out !== 16'hD79F || locked_out !== 1'b0) begin
      failures++;
      $display("FAIL seed_pred: exp=%h locked=%b, required d79f 0", expected_out, locked_out);
    end
    w = 16'hD79F;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, w);
      w = nxt(w);
      checks++;
      if (locked_out !== (i == 3)) begin
        failures++;
        $display("FAIL lock_rise[%0d]: locked=%b, required %b", i, locked_out, (i == 3));
      end
      if (i == 0) begin
        checks++;
        if (expected_out !== 16'h2F3B) begin
          failures++;
          $display("FAIL pred_after_d79f: exp=%h, required 2f3b", expected_out);
        end
      end
    end
    checks++;
    if (expected_out !== w || err_count_out !== 4'd0) begin
      failures++;
      $display("FAIL locked_state: exp=%h err=%0d, required %h 0", expected_out, err_count_out, w);
    end
    $display("test_lock: locked=%b expected=%h", locked_out, expected_out);
  endtask

  task automatic test_single_error();
    beat(1'b1, ~w);
    w = nxt(w);
    exp_err++;
    checks++;
    if (err_pulse_out !== 1'b1 || err_count_out !== 4'(exp_err) || locked_out !== 1'b1 ||
        expected_out !== w) begin
      failures++;
      $display("FAIL single_err: pulse=%b err=%0d locked=%b exp=%h, required 1 %0d 1 %h",
               err_pulse_out, err_count_out, locked_out, expected_out, exp_err, w);
    end
    beat(1'b0, 16'h0000);
    checks++;
    if (err_pulse_out !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width: pulse=%b, required 0", err_pulse_out);
    end
    beat(1'b1, w);
    w = nxt(w);
    checks++;
    if (err_pulse_out !== 1'b0 || err_count_out !== 4'(exp_err) || locked_out !== 1'b1) begin
      failures++;
      $display("FAIL after_good: pulse=%b err=%0d locked=%b, required 0 %0d 1",
               err_pulse_out, err_count_out, locked_out, exp_err);
    end
    $display("test_single_error: err=%0d locked=%b", err_count_out, locked_out);
  endtask

  task automatic test_unlock();
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, ~w);
      w = nxt(w);
      exp_err++;
      checks++;
      if (err_pulse_out !== 1'b1 || err_count_out !== 4'(exp_err) || locked_out !== (i < 2)) begin
        failures++;
        $display("FAIL unlock[%0d]: pulse=%b err=%0d locked=%b, required 1 %0d %b",
                 i, err_pulse_out, err_count_out, locked_out, exp_err, (i < 2));
      end
    end
    relock();
    checks++;
    if (locked_out !== 1'b1 || expected_out !== w || err_count_out !== 4'(exp_err)) begin
      failures++;
      $display("FAIL relock: locked=%b exp=%h err=%0d, required 1 %h %0d",
               locked_out, expected_out, err_count_out, w, exp_err);
    end
    $display("test_unlock: err=%0d relocked=%b", err_count_out, locked_out);
  endtask

  task automatic test_stall();
    for (int g = 0; g < 10; g++) begin
      int gap;
      gap = int'($urandom_range(1, 3));
      for (int k = 0; k < gap; k++) begin
        beat(1'b0, 16'(~w));
        checks++;
        if (expected_out !== w || err_pulse_out !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold[%0d]: exp=%h pulse=%b, required %h 0",
                   g, expected_out, err_pulse_out, w);
        end
      end
      beat(1'b1, w);
      w = nxt(w);
      checks++;
      if (expected_out !== w || err_count_out !== 4'(exp_err) || locked_out !== 1'b1) begin
        failures++;
        $display("FAIL stall_adv[%0d]: exp=%h err=%0d locked=%b, required %h %0d 1",
                 g, expected_out, err_count_out, locked_out, w, exp_err);
      end
    end
    $display("test_stall: expected=%h err=%0d", expected_out, err_count_out);
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 10; r++) begin
      for (int m = 0; m < 2; m++) begin
        beat(1'b1, ~w);
        w = nxt(w);
        if (exp_err < 15) exp_err++;
        checks++;
        if (err_count_out !== 4'(exp_err) || err_pulse_out !== 1'b1) begin
          failures++;
          $display("FAIL sat[%0d.%0d]: err=%0d pulse=%b, required %0d 1",
                   r, m, err_count_out, err_pulse_out, exp_err);
        end
      end
      beat(1'b1, w);
      w = nxt(w);
    end
    for (int m = 0; m < 3; m++) begin
      beat(1'b1, ~w);
      w = nxt(w);
    end
    relock();
    checks++;
    if (err_count_out !== 4'd15 || locked_out !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold: err=%0d locked=%b, required 15 1", err_count_out, locked_out);
    end
    $display("test_saturation: err=%0d locked=%b", err_count_out, locked_out);
  endtask

  task automatic test_reset_midstream();
    @(negedge clk_in);
    rst_in        = 1'b1;
    data_valid_in = 1'b1;
    data_in       = ~w;
    @(posedge clk_in);
    #1;
    rst_in        = 1'b0;
    data_valid_in = 1'b0;
    checks++;
    if (locked_out !== 1'b0 || err_pulse_out !== 1'b0 || err_count_out !== 4'd0 ||
        expected_out !== 16'hABCD) begin
      failures++;
      $display("FAIL mid_reset: locked=%b pulse=%b err=%0d exp=%h, required 0 0 0 abcd",
               locked_out, err_pulse_out, err_count_out, expected_out);
    end
    exp_err = 0;
    $display("test_reset_midstream: locked=%b err=%0d expected=%h",
             locked_out, err_count_out, expected_out);
  endtask

  task automatic test_zero_garbage();
    logic [15:0] garbage [8];
    garbage = '{16'h1234, 16'h1234, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h5555, 16'h0F0F, 16'h0001};
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 16'h0000);
      checks++;
      if (locked_out !== 1'b0 || expected_out !== 16'hABCD) begin
        failures++;
        $display("FAIL zero_hunt[%0d]: locked=%b exp=%h, required 0 abcd",
                 i, locked_out, expected_out);
      end
`ifdef LFSR_CHK_ZERO_DET_EN
      checks++;
      if (stuck_zero_out !== (i == 2)) begin
        failures++;
        $display("FAIL stuck_zero[%0d]: stuck=%b, required %b", i, stuck_zero_out, (i == 2));
      end
`endif
    end
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, garbage[i]);
      checks++;
      if (locked_out !== 1'b0 || err_count_out !== 4'd0 || err_pulse_out !== 1'b0) begin
        failures++;
        $display("FAIL garbage[%0d]: locked=%b err=%0d pulse=%b, required 0 0 0",
                 i, locked_out, err_count_out, err_pulse_out);
      end
`ifdef LFSR_CHK_ZERO_DET_EN
      if (i == 0) begin
        checks++;
        if (stuck_zero_out !== 1'b0) begin
          failures++;
          $display("FAIL stuck_clear: stuck=%b, required 0", stuck_zero_out);
        end
      end
`endif
    end
    checks++;
    if (expected_out !== nxt(16'h0001)) begin
      failures++;
      $display("FAIL garbage_reseed: exp=%h, required %h", expected_out, nxt(16'h0001));
    end
    $display("test_zero_garbage: locked=%b err=%0d", locked_out, err_count_out);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    exp_err       = 0;
    w             = 16'h0000;
    rst_in        = 1'b1;
    data_valid_in = 1'b0;
    data_in       = 16'h0000;
    test_reset();
    test_lock();
    test_single_error();
    test_unlock();
    test_stall();
    test_saturation();
    test_reset_midstream();
    test_zero_garbage();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
